// File: rtl/dsp_pkg.sv
// Shared DSP constants and the chunk filter state encoding.
// Widths here are the defaults used by every block in the audio datapath.
package dsp_pkg;

    localparam int SAMPLE_SIZE = 24;
    localparam int PTR_BITS    = 6;
    localparam int BUFF_SIZE   = 64;
    localparam int COEF_W      = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fir_state_t;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer plus rising-edge detector for a slow pulse from another domain.
// Strobe is one clk wide, two clk after the input rises; pulse width is irrelevant.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic strobe
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign strobe = r_sync & ~r_prev;

endmodule

// File: rtl/chunk_fir_filter.sv
// 4-tap FIR over one rx chunk per start pulse; sample p is written 3 clk after its read address.
// No backpressure: a start while busy is dropped and latched in the sticky overrun flag.
module chunk_fir_filter #(
    parameter int                                SAMPLE_SIZE = dsp_pkg::SAMPLE_SIZE,
    parameter int                                PTR_BITS    = dsp_pkg::PTR_BITS,
    parameter int                                BUFF_SIZE   = dsp_pkg::BUFF_SIZE,
    parameter logic signed [dsp_pkg::COEF_W-1:0] C0          = 18'sd16384,
    parameter logic signed [dsp_pkg::COEF_W-1:0] C1          = 18'sd16384,
    parameter logic signed [dsp_pkg::COEF_W-1:0] C2          = 18'sd16384,
    parameter logic signed [dsp_pkg::COEF_W-1:0] C3          = 18'sd16384,
    parameter int                                SHIFT       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          chunk_pulse,
    output logic [PTR_BITS-1:0]           input_buff_ptr,
    input  logic signed [SAMPLE_SIZE-1:0] input_buff_sample,
    output logic [PTR_BITS-1:0]           output_buff_ptr,
    output logic signed [SAMPLE_SIZE-1:0] output_buff_sample,
    output logic                          output_buff_we,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);

    import dsp_pkg::COEF_W;
    import dsp_pkg::fir_state_t;
    import dsp_pkg::ST_IDLE;
    import dsp_pkg::ST_RUN;
    import dsp_pkg::ST_DRAIN;

    localparam int                 PROD_W   = SAMPLE_SIZE + COEF_W;
    localparam int                 ACC_W    = PROD_W + 2;
    localparam int                 RND_W    = ACC_W + 1;
    localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(BUFF_SIZE - 1);
    localparam logic signed [RND_W-1:0] RND_ADD = RND_W'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((64'sd1 <<< (SAMPLE_SIZE - 1)) - 64'sd1);
    localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(64'sd1 <<< (SAMPLE_SIZE - 1)));

    fir_state_t                     r_state;
    fir_state_t                     w_state_nxt;
    logic                           w_start;
    logic                           w_busy;
    logic                           w_issue;
    logic                           w_last_wr;
    logic [PTR_BITS-1:0]            r_rd_ptr;
    logic                           r_v1, r_v2, r_v3;
    logic [PTR_BITS-1:0]            r_p1, r_p2, r_p3;
    logic signed [SAMPLE_SIZE-1:0]  r_x0, r_x1, r_x2, r_x3;
    logic signed [PROD_W-1:0]       w_prod0, w_prod1, w_prod2, w_prod3;
    logic signed [ACC_W-1:0]        w_sum;
    logic signed [ACC_W-1:0]        r_acc;
    logic signed [RND_W-1:0]        w_rnd;
    logic signed [RND_W-1:0]        w_shr;
    logic signed [SAMPLE_SIZE-1:0]  w_sat;
    logic                           r_done;
    logic                           r_overrun;

    pulse_sync u_pulse_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (chunk_pulse),
        .strobe   (w_start)
    );

    assign w_last_wr = r_v3 && (r_p3 == LAST_PTR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_busy  = 1'b1;
                w_issue = 1'b1;
                if (r_rd_ptr == LAST_PTR) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_last_wr) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     r_rd_ptr <= '0;
        else if (w_issue && (r_rd_ptr != LAST_PTR)) r_rd_ptr <= r_rd_ptr + 1'b1;
        else                                         r_rd_ptr <= '0;
    end

    // History only advances on a valid capture, so it carries over between chunks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_p1  <= '0;
            r_p2  <= '0;
            r_p3  <= '0;
            r_x0  <= '0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_x3  <= '0;
            r_acc <= '0;
        end else begin
            r_v1 <= w_issue;
            r_p1 <= r_rd_ptr;
            r_v2 <= r_v1;
            r_p2 <= r_p1;
            r_v3 <= r_v2;
            r_p3 <= r_p2;
            if (r_v1) begin
                r_x0 <= input_buff_sample;
                r_x1 <= r_x0;
                r_x2 <= r_x1;
                r_x3 <= r_x2;
            end
            if (r_v2) r_acc <= w_sum;
        end
    end

    always_comb begin
        w_prod0 = PROD_W'(r_x0) * PROD_W'(C0);
        w_prod1 = PROD_W'(r_x1) * PROD_W'(C1);
        w_prod2 = PROD_W'(r_x2) * PROD_W'(C2);
        w_prod3 = PROD_W'(r_x3) * PROD_W'(C3);
        w_sum   = ACC_W'(w_prod0) + ACC_W'(w_prod1) + ACC_W'(w_prod2) + ACC_W'(w_prod3);
    end

    always_comb begin
        w_rnd = RND_W'(r_acc) + RND_ADD;
        w_shr = w_rnd >>> SHIFT;
        if (w_shr > SAT_MAX)      w_sat = {1'b0, {(SAMPLE_SIZE-1){1'b1}}};
        else if (w_shr < SAT_MIN) w_sat = {1'b1, {(SAMPLE_SIZE-1){1'b0}}};
        else                      w_sat = w_shr[SAMPLE_SIZE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= w_last_wr;
            r_overrun <= r_overrun | (w_start & w_busy);
        end
    end

    assign input_buff_ptr     = r_rd_ptr;
    assign output_buff_ptr    = r_p3;
    assign output_buff_sample = w_sat;
    assign output_buff_we     = r_v3;
    assign busy               = w_busy;
    assign done               = r_done;
    assign overrun            = r_overrun;

endmodule

// File: tb/tb_chunk_fir_filter.sv
// Directed bench for chunk_fir_filter: a default-coefficient instance and a 32767-coefficient
// instance share one rx buffer model; expected outputs are hand-computed constants.
module tb_chunk_fir_filter;

    localparam int N = 64;

    logic clk = 1'b0;
    logic rst;
    logic chunk_pulse;

    logic [5:0]         ib_ptr_d, ob_ptr_d, ib_ptr_s, ob_ptr_s;
    logic signed [23:0] ib_dat_d, ib_dat_s, ob_dat_d, ob_dat_s;
    logic               we_d, busy_d, done_d, ovr_d;
    logic               we_s, busy_s, done_s, ovr_s;

    int mem [N];
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        ib_dat_d <= 24'(mem[ib_ptr_d]);
        ib_dat_s <= 24'(mem[ib_ptr_s]);
    end

    chunk_fir_filter dut (
        .clk                (clk),
        .rst                (rst),
        .chunk_pulse        (chunk_pulse),
        .input_buff_ptr     (ib_ptr_d),
        .input_buff_sample  (ib_dat_d),
        .output_buff_ptr    (ob_ptr_d),
        .output_buff_sample (ob_dat_d),
        .output_buff_we     (we_d),
        .busy               (busy_d),
        .done               (done_d),
        .overrun            (ovr_d)
    );

    chunk_fir_filter #(
        .C0 (18'sd32767),
        .C1 (18'sd32767),
        .C2 (18'sd32767),
        .C3 (18'sd32767)
    ) dut_sat (
        .clk                (clk),
        .rst                (rst),
        .chunk_pulse        (chunk_pulse),
        .input_buff_ptr     (ib_ptr_s),
        .input_buff_sample  (ib_dat_s),
        .output_buff_ptr    (ob_ptr_s),
        .output_buff_sample (ob_dat_s),
        .output_buff_we     (we_s),
        .busy               (busy_s),
        .done               (done_s),
        .overrun            (ovr_s)
    );

    // Free-running monitor; the main sequence works on deltas of these counters.
    int wr_cnt = 0, done_cnt = 0, run_cnt = 0, addr_err = 0, tim_err = 0;
    int run_start = 0, done_cyc = 0, busy_at_done = 0;
    int wcount [N];
    int out_d  [N];
    int out_s  [N];
    bit prev_busy = 1'b0;

    always @(negedge clk) begin
        if (busy_d && !prev_busy) begin
            run_cnt   = run_cnt + 1;
            run_start = cyc;
        end
        prev_busy = busy_d;
        if (busy_d && (cyc - run_start) < N && int'(ib_ptr_d) != (cyc - run_start))
            addr_err = addr_err + 1;
        if (!busy_d && ib_ptr_d != 6'd0)
            addr_err = addr_err + 1;
        if (we_d) begin
            wr_cnt = wr_cnt + 1;
            wcount[ob_ptr_d] = wcount[ob_ptr_d] + 1;
            out_d[ob_ptr_d]  = int'(ob_dat_d);
            if ((cyc - run_start) != int'(ob_ptr_d) + 3) tim_err = tim_err + 1;
        end
        if (we_s) out_s[ob_ptr_s] = int'(ob_dat_s);
        if (done_d) begin
            done_cnt     = done_cnt + 1;
            done_cyc     = cyc;
            busy_at_done = int'(busy_d);
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int b_wr, b_done, b_run, b_addr, b_tim;
    int bw [N];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        b_wr   = wr_cnt;
        b_done = done_cnt;
        b_run  = run_cnt;
        b_addr = addr_err;
        b_tim  = tim_err;
        for (int p = 0; p < N; p++) bw[p] = wcount[p];
    endtask

    task automatic fire_pulse();
        @(posedge clk); #1;
        chunk_pulse = 1'b1;
        repeat (3) @(posedge clk);
        #1 chunk_pulse = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int g = 0;
        while ((done_cnt - b_done) < target && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if ((done_cnt - b_done) < target) check("done timeout", done_cnt - b_done, target);
    endtask

    task automatic wait_run(input int target);
        int g = 0;
        while ((run_cnt - b_run) < target && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if ((run_cnt - b_run) < target) check("run start timeout", run_cnt - b_run, target);
    endtask

    task automatic wait_cycle(input int c);
        int g = 0;
        while (cyc != c && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (cyc != c) check("cycle wait timeout", cyc, c);
    endtask

    task automatic chunk_checks(input string tag, input int n);
        int bad = 0;
        for (int p = 0; p < N; p++) if (wcount[p] - bw[p] != n) bad++;
        check($sformatf("%s run count", tag), run_cnt - b_run, n);
        check($sformatf("%s done count", tag), done_cnt - b_done, n);
        check($sformatf("%s done latency", tag), done_cyc - run_start, 67);
        check($sformatf("%s busy at done", tag), busy_at_done, 0);
        check($sformatf("%s write count", tag), wr_cnt - b_wr, 64 * n);
        check($sformatf("%s addresses not written exactly once", tag), bad, 0);
        check($sformatf("%s read address errors", tag), addr_err - b_addr, 0);
        check($sformatf("%s write timing errors", tag), tim_err - b_tim, 0);
    endtask

    task automatic run_chunk(input string tag);
        snap();
        fire_pulse();
        wait_done(1);
        repeat (4) @(posedge clk);
        #1;
        chunk_checks(tag, 1);
    endtask

    task automatic fill_mem(input int first, input int fill);
        for (int p = 0; p < N; p++) mem[p] = (p == 0) ? first : fill;
    endtask

    typedef struct {
        string tag;
        int    fill;
        int    first;
        bit    sat;
        int    e0, e1, e2, e3, er;
    } vec_t;

    vec_t tbl [7];

    function automatic int exp_at(input vec_t v, input int p);
        case (p)
            0:       return v.e0;
            1:       return v.e1;
            2:       return v.e2;
            3:       return v.e3;
            default: return v.er;
        endcase
    endfunction

    initial begin
        int s0, d0, wr_before;

        tbl[0] = '{"impulse",     0,        1048576,  1'b0, 262144,  262144,  262144,   262144,   0};
        tbl[1] = '{"dc4096",      4096,     4096,     1'b0, 1024,    2048,    3072,     4096,     4096};
        tbl[2] = '{"history",     0,        0,        1'b0, 3072,    2048,    1024,     0,        0};
        tbl[3] = '{"satpos warm", 8388607,  8388607,  1'b1, 4194176, 8388351, 8388607,  8388607,  8388607};
        tbl[4] = '{"satpos",      8388607,  8388607,  1'b1, 8388607, 8388607, 8388607,  8388607,  8388607};
        tbl[5] = '{"satneg warm", -8388608, -8388608, 1'b1, 8388351, -1,      -8388352, -8388608, -8388608};
        tbl[6] = '{"satneg",      -8388608, -8388608, 1'b1, -8388608, -8388608, -8388608, -8388608, -8388608};

        rst = 1'b1;
        chunk_pulse = 1'b0;
        for (int p = 0; p < N; p++) begin
            mem[p] = 0;
            wcount[p] = 0;
            out_d[p] = 0;
            out_s[p] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy_d, 0);
        check("reset done", done_d, 0);
        check("reset overrun", ovr_d, 0);
        check("reset we", we_d, 0);
        check("reset in ptr", ib_ptr_d, 0);
        check("reset out ptr", ob_ptr_d, 0);
        check("reset sample", ob_dat_d, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            fill_mem(tbl[i].first, tbl[i].fill);
            run_chunk(tbl[i].tag);
            for (int p = 0; p < N; p++)
                check($sformatf("%s y[%0d]", tbl[i].tag, p),
                      tbl[i].sat ? out_s[p] : out_d[p], exp_at(tbl[i], p));
        end

        // Start strobe landing in the done cycle must be accepted without overrun.
        fill_mem(0, 0);
        snap();
        fire_pulse();
        wait_run(1);
        s0 = run_start;
        wait_cycle(s0 + 65);
        chunk_pulse = 1'b1;
        wait_done(1);
        d0 = done_cyc;
        check("b2b first done latency", d0 - s0, 67);
        wait_run(2);
        check("b2b restart cycle", run_start - s0, 68);
        chunk_pulse = 1'b0;
        wait_done(2);
        repeat (4) @(posedge clk);
        #1;
        chunk_checks("b2b", 2);
        check("b2b overrun", ovr_d, 0);

        // Second pulse 20 clk into RUN.
        snap();
        fire_pulse();
        wait_run(1);
        s0 = run_start;
        wait_cycle(s0 + 20);
        chunk_pulse = 1'b1;
        repeat (3) @(posedge clk);
        #1 chunk_pulse = 1'b0;
        wait_done(1);
        repeat (20) @(posedge clk);
        #1;
        chunk_checks("overrun", 1);
        check("overrun flag set", ovr_d, 1);
        run_chunk("clean after overrun");
        check("overrun flag sticky", ovr_d, 1);

        // Reset at RUN cycle 30 with non-zero history in flight.
        fill_mem(4096, 4096);
        snap();
        fire_pulse();
        wait_run(1);
        s0 = run_start;
        wait_cycle(s0 + 30);
        rst = 1'b1;
        #1;
        wr_before = wr_cnt;
        check("midrst we", we_d, 0);
        check("midrst busy", busy_d, 0);
        check("midrst done", done_d, 0);
        check("midrst overrun", ovr_d, 0);
        check("midrst in ptr", ib_ptr_d, 0);
        check("midrst out ptr", ob_ptr_d, 0);
        check("midrst sample", ob_dat_d, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("midrst no done", done_cnt - b_done, 0);
        check("midrst no writes after reset", wr_cnt - wr_before, 0);
        check("midrst partial writes", wr_before - b_wr, 27);

        fill_mem(1048576, 0);
        run_chunk("post reset");
        for (int p = 0; p < 6; p++)
            check($sformatf("post reset y[%0d]", p), out_d[p], (p < 4) ? 262144 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
